// File: rtl/sine_quarter_lut.sv
// Quarter-wave sine magnitude: 257-point ROM with 5-bit linear interpolation.
// The output is registered with one cycle of latency.
module sine_quarter_lut (
    input  logic        clk,
    input  logic        rst,
    input  logic [12:0] v,
    output logic [15:0] sv
);

    // pi in Q60 fixed point (hex expansion of pi, truncated)
    localparam logic [63:0] PI_Q60 = 64'h3243F6A8885A308D;

    // Elaboration-time Taylor series in Q60. It yields round(32767*sin(pi*k/512))
    // so the ROM contents never need to be maintained by hand.
    function automatic logic [15:0] sine_entry(input int unsigned k);
        logic [127:0] x;
        logic [127:0] x2;
        logic [127:0] term;
        logic [127:0] sum;
        x    = (128'(PI_Q60) * 128'(k)) >> 9;
        x2   = (x * x) >> 60;
        term = x;
        sum  = x;
        for (int unsigned n = 1; n <= 15; n++) begin
            term = ((term * x2) >> 60) / 128'((2 * n) * (2 * n + 1));
            if ((n % 2) == 1)
                sum = sum - term;
            else
                sum = sum + term;
        end
        return 16'((sum * 128'd32767 + (128'd1 << 59)) >> 60);
    endfunction

    logic [15:0] w_rom [257];

    for (genvar k = 0; k < 257; k++) begin : g_rom
        localparam logic [15:0] TK = sine_entry(k);
        assign w_rom[k] = TK;
    end

    logic [7:0]  w_i;
    logic [4:0]  w_f;
    logic [8:0]  w_i_hi;
    logic [15:0] w_lo;
    logic [15:0] w_hi;
    logic [15:0] w_diff;
    logic [20:0] w_prod;
    logic [15:0] w_sum;
    logic [15:0] r_sv;

    assign w_i    = v[12:5];
    assign w_f    = v[4:0];
    // The upper neighbour index is 9 bits wide so that i=255 reaches T[256] without wrapping.
    assign w_i_hi = {1'b0, w_i} + 9'd1;
    assign w_lo   = w_rom[w_i];
    assign w_hi   = w_rom[w_i_hi];
    assign w_diff = w_hi - w_lo;
    assign w_prod = 21'(w_diff) * 21'(w_f);
    assign w_sum  = w_lo + 16'(w_prod >> 5);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_sv <= '0;
        else
            r_sv <= w_sum;
    end

    assign sv = r_sv;

endmodule

// File: tb/tb_sine_quarter_lut.sv
// Directed bench for sine_quarter_lut; its reference table is built from real-valued $sin.
module tb_sine_quarter_lut;

    logic        clk;
    logic        rst;
    logic [12:0] v;
    logic [15:0] sv;

    int n_cmp;
    int n_bad;
    int T [257];

    sine_quarter_lut dut (
        .clk (clk),
        .rst (rst),
        .v   (v),
        .sv  (sv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int model(input int vv);
        int i;
        int f;
        i = vv / 32;
        f = vv % 32;
        return T[i] + (((T[i + 1] - T[i]) * f) >>> 5);
    endfunction

    task automatic build_table();
        real pi;
        pi = 3.14159265358979323846;
        for (int k = 0; k < 257; k++)
            T[k] = $rtoi(32767.0 * $sin(pi * k / 512.0) + 0.5);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            v = 13'(1000 * c + 77);
            @(posedge clk);
            #1;
            n_cmp++;
            if (sv !== 16'd0) begin
                n_bad++;
                $display("FAIL reset_hold: sv=%0d expected=0", sv);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        v = 13'd4096;
        @(posedge clk);
        #1;
        n_cmp++;
        if (sv !== 16'd23170) begin
            n_bad++;
            $display("FAIL reset_release: sv=%0d expected=23170", sv);
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (sv !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_async: sv=%0d expected=0", sv);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_table_points();
        int vin [4];
        int exp_v [4];
        vin   = '{0, 32, 4096, 8160};
        exp_v = '{0, 201, 23170, 32766};
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            v = 13'(vin[j]);
            @(posedge clk);
            #1;
            n_cmp++;
            if (sv !== 16'(exp_v[j])) begin
                n_bad++;
                $display("FAIL table_point v=%0d: sv=%0d expected=%0d", vin[j], sv, exp_v[j]);
            end
        end
    endtask

    task automatic test_interp();
        int vin [3];
        int exp_v [3];
        vin   = '{16, 31, 8191};
        exp_v = '{100, 194, 32766};
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            v = 13'(vin[j]);
            @(posedge clk);
            #1;
            n_cmp++;
            if (sv !== 16'(exp_v[j])) begin
                n_bad++;
                $display("FAIL interp v=%0d: sv=%0d expected=%0d", vin[j], sv, exp_v[j]);
            end
        end
    endtask

    task automatic test_hold();
        @(negedge clk);
        v = 13'd1234;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if (sv !== 16'(model(1234))) begin
                n_bad++;
                $display("FAIL hold: sv=%0d expected=%0d", sv, model(1234));
            end
        end
    endtask

    task automatic test_back_to_back();
        int prev;
        int mx;
        prev = 0;
        mx   = 0;
        for (int x = 0; x < 8192; x++) begin
            @(negedge clk);
            v = 13'(x);
            @(posedge clk);
            #1;
            n_cmp++;
            if (sv !== 16'(model(x))) begin
                n_bad++;
                $display("FAIL sweep v=%0d: sv=%0d expected=%0d", x, sv, model(x));
            end
            n_cmp++;
            if (int'(sv) < prev || sv[15] !== 1'b0) begin
                n_bad++;
                $display("FAIL monotonic v=%0d: sv=%0d previous=%0d", x, sv, prev);
            end
            prev = int'(sv);
            if (prev > mx) mx = prev;
        end
        n_cmp++;
        if (mx != 32766) begin
            n_bad++;
            $display("FAIL sweep_max: max=%0d expected=32766", mx);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b1;
        v     = '0;
        build_table();
        test_reset();
        test_table_points();
        test_interp();
        test_hold();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sine_quarter_lut.md
Name: sine_quarter_lut

Overview:
- Registered quarter-wave sine magnitude generator for the correlator's carrier DDS path.
- The caller drives a 13-bit phase index `v` covering one quarter period. The caller already mirrors this index for quadrants 1 and 3, and applies the sign for quadrants 2 and 3.
- The block returns the unsigned sine magnitude on `sv`, scaled to a 15-bit full scale (max 32767).
- Implementation is a 257-point table plus linear interpolation, registered on the output.

Parameters:
- None. Widths are fixed: index 13 bits, output 16 bits, table 257 entries.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous, active-high. Clears the output register.
- v  input  13  quarter-wave phase index, 0..8191. 0 corresponds to angle 0; 8192 would correspond to pi/2.
- sv  output  16  registered sine magnitude, unsigned, range 0..32767. Bit 15 is always 0.

Behaviour:
- Reset: clock and reset ports are named `clk` and `rst`; reset is asynchronous and active-high.
  - While `rst`=1, `sv`=0 regardless of `clk`.
  - After `rst` falls, `sv` updates on the first rising `clk` edge.
  - `rst` asserted mid-operation clears `sv` immediately (asynchronously); no other state exists.
- Table T[k], k=0..256: T[k] = round(32767*sin(pi*k/512)), round half away from zero.
  - Anchor values: T[0]=0, T[1]=201, T[128]=23170, T[255]=32766, T[256]=32767.
  - T is a constant ROM, never written.
- Index split: i = v[12:5] (0..255), f = v[4:0] (0..31).
- Interpolation: s = T[i] + (((T[i+1]-T[i]) * f) >> 5).
  - The difference is always >= 0, so the product is unsigned.
  - Product width is at least 21 bits, with no overflow.
  - The shift truncates toward zero.
- Output: `sv` <= s on every rising `clk` edge when `rst`=0.
  - Latency is exactly 1 cycle: the `v` value sampled at edge N appears on `sv` after edge N.
  - No enable and no handshake; the block accepts a new `v` every cycle.
- Boundaries:
  - v=0 gives 0.
  - v=8191 (i=255, f=31) uses T[256]=32767 as the upper neighbour and gives 32766. The index never wraps.
  - Output is monotonically non-decreasing in `v`.
  - `sv` is never negative and never exceeds 32767.
- `v` holding constant keeps `sv` constant. X-free: every 13-bit input maps to a defined value.
- Synthesisable as one ROM (case or initialised array), one subtract, one 9x5-bit-class multiply, one add and a 16-bit register.

Test Plan:
- Reset: hold `rst`=1 and toggle `v` and `clk` -> `sv`=0 throughout. Assert `rst` asynchronously mid-stream with `sv`=23170 -> `sv`=0 immediately, without waiting for a clock edge.
- Table points: v=0, 32, 4096, 8160 on consecutive cycles -> `sv`=0, 201, 23170, T[255]=32766, each one cycle after its input.
- Interpolation: v=16 -> 100 (0 + (201*16>>5)); v=31 -> 194 (201*31>>5=194).
- Upper boundary: v=8191 -> 32766. Sweep all 8192 values -> `sv` is monotonic non-decreasing, max 32766, bit 15 always 0.
- Latency and throughput: drive an incrementing `v` every cycle -> each `sv` equals the golden model of the previous cycle's `v`, with no bubbles.
- Full comparison: all 8192 inputs against a reference model computing T and the interpolation formula -> exact match.
